// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with enable, pixel divider and registered outputs
module vga_timing_gen #(
    parameter int H_RES   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_RES   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter bit H_POL   = 1'b0,
    parameter bit V_POL   = 1'b0,
    parameter int CLK_DIV = 1,
    parameter int CNT_W   = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] hpos,
    output logic [CNT_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic             line_start,
    output logic             frame_start,
    output logic             pix_tick
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_RES);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_RES);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_RES + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_RES + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_RES + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_RES + V_FP + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             advance;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             hs_act_next;
    logic             vs_act_next;

    // Outputs are decoded from the position being entered so every output is aligned.
    always_comb begin
        advance = en && (div == DIV_LAST);
        h_next  = hpos + CNT_W'(1);
        v_next  = vpos;
        if (hpos == H_LAST) begin
            h_next = '0;
            v_next = (vpos == V_LAST) ? '0 : vpos + CNT_W'(1);
        end
        hs_act_next = (h_next >= HS_START) && (h_next < HS_END);
        vs_act_next = (v_next >= VS_START) && (v_next < VS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (!en || advance) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            pix_tick    <= 1'b0;
        end else begin
            pix_tick <= advance;
            if (advance) begin
                hpos        <= h_next;
                vpos        <= v_next;
                hsync       <= hs_act_next ? H_POL : ~H_POL;
                vsync       <= vs_act_next ? V_POL : ~V_POL;
                display_on  <= (h_next < H_ACT) && (v_next < V_ACT);
                line_start  <= (h_next == '0);
                frame_start <= (h_next == '0) && (v_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // d_: default mode, s_: small mode with active-high hsync, k_: CLK_DIV=4, t_: short lines, default vertical
    logic d_rst_n, d_en, d_hs, d_vs, d_de, d_ls, d_fs, d_pt;
    logic s_rst_n, s_en, s_hs, s_vs, s_de, s_ls, s_fs, s_pt;
    logic k_rst_n, k_en, k_hs, k_vs, k_de, k_ls, k_fs, k_pt;
    logic t_rst_n, t_en, t_hs, t_vs, t_de, t_ls, t_fs, t_pt;
    logic [10:0] d_h, d_v, s_h, s_v, k_h, k_v, t_h, t_v;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(d_rst_n), .en(d_en), .hpos(d_h), .vpos(d_v), .hsync(d_hs), .vsync(d_vs),
        .display_on(d_de), .line_start(d_ls), .frame_start(d_fs), .pix_tick(d_pt)
    );

    vga_timing_gen #(
        .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1)
    ) u_small (
        .clk(clk), .rst_n(s_rst_n), .en(s_en), .hpos(s_h), .vpos(s_v), .hsync(s_hs), .vsync(s_vs),
        .display_on(s_de), .line_start(s_ls), .frame_start(s_fs), .pix_tick(s_pt)
    );

    vga_timing_gen #(.CLK_DIV(4)) u_div (
        .clk(clk), .rst_n(k_rst_n), .en(k_en), .hpos(k_h), .vpos(k_v), .hsync(k_hs), .vsync(k_vs),
        .display_on(k_de), .line_start(k_ls), .frame_start(k_fs), .pix_tick(k_pt)
    );

    vga_timing_gen #(.H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(1)) u_tall (
        .clk(clk), .rst_n(t_rst_n), .en(t_en), .hpos(t_h), .vpos(t_v), .hsync(t_hs), .vsync(t_vs),
        .display_on(t_de), .line_start(t_ls), .frame_start(t_fs), .pix_tick(t_pt)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({d_h, d_v} !== {11'd799, 11'd524}) begin
            n_fail++; $display("FAIL reset_def_pos: got %0d,%0d expected 799,524", d_h, d_v);
        end
        n_checks++;
        if ({d_hs, d_vs, d_de, d_ls, d_fs, d_pt} !== 6'b110000) begin
            n_fail++; $display("FAIL reset_def_flags: got %b expected 110000", {d_hs, d_vs, d_de, d_ls, d_fs, d_pt});
        end
        n_checks++;
        if ({s_h, s_v, s_hs, s_vs, s_de, s_ls, s_fs, s_pt} !== {11'd13, 11'd6, 6'b010000}) begin
            n_fail++; $display("FAIL reset_small: got %0d,%0d %b expected 13,6 010000", s_h, s_v,
                               {s_hs, s_vs, s_de, s_ls, s_fs, s_pt});
        end
        n_checks++;
        if ({k_h, k_v, k_hs, k_vs, k_de, k_ls, k_fs, k_pt} !== {11'd799, 11'd524, 6'b110000}) begin
            n_fail++; $display("FAIL reset_div: got %0d,%0d %b expected 799,524 110000", k_h, k_v,
                               {k_hs, k_vs, k_de, k_ls, k_fs, k_pt});
        end
        n_checks++;
        if ({t_h, t_v, t_hs, t_vs, t_de, t_ls, t_fs, t_pt} !== {11'd13, 11'd524, 6'b110000}) begin
            n_fail++; $display("FAIL reset_tall: got %0d,%0d %b expected 13,524 110000", t_h, t_v,
                               {t_hs, t_vs, t_de, t_ls, t_fs, t_pt});
        end
    endtask

    task automatic test_first_pixel();
        d_rst_n = 1'b1;
        d_en    = 1'b1;
        step();
        n_checks++;
        if ({d_h, d_v, d_hs, d_vs, d_de, d_ls, d_fs, d_pt} !== {11'd0, 11'd0, 6'b111111}) begin
            n_fail++; $display("FAIL first_pixel: got %0d,%0d %b expected 0,0 111111", d_h, d_v,
                               {d_hs, d_vs, d_de, d_ls, d_fs, d_pt});
        end
    endtask

    task automatic test_hsync_line();
        logic exp_hs, exp_de;
        for (int i = 1; i < 800; i++) begin
            step();
            exp_hs = !(i >= 656 && i <= 751);
            exp_de = (i < 640);
            n_checks++;
            if ({d_h, d_v, d_hs, d_de, d_ls, d_fs, d_pt} !== {11'(i), 11'd0, exp_hs, exp_de, 3'b001}) begin
                n_fail++; $display("FAIL line0_px: got h=%0d v=%0d hs=%b de=%b ls=%b fs=%b pt=%b expected h=%0d v=0 hs=%b de=%b ls=0 fs=0 pt=1",
                                   d_h, d_v, d_hs, d_de, d_ls, d_fs, d_pt, i, exp_hs, exp_de);
            end
        end
        step();
        n_checks++;
        if ({d_h, d_v, d_ls, d_fs, d_de} !== {11'd0, 11'd1, 3'b101}) begin
            n_fail++; $display("FAIL line_wrap: got %0d,%0d ls=%b fs=%b de=%b expected 0,1 ls=1 fs=0 de=1",
                               d_h, d_v, d_ls, d_fs, d_de);
        end
    endtask

    task automatic test_en_freeze();
        repeat (100) step();
        n_checks++;
        if ({d_h, d_v} !== {11'd100, 11'd1}) begin
            n_fail++; $display("FAIL freeze_entry: got %0d,%0d expected 100,1", d_h, d_v);
        end
        d_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if ({d_h, d_v, d_hs, d_vs, d_de, d_ls, d_fs, d_pt} !== {11'd100, 11'd1, 6'b111000}) begin
                n_fail++; $display("FAIL freeze_hold: clk %0d got %0d,%0d %b expected 100,1 111000", i, d_h, d_v,
                                   {d_hs, d_vs, d_de, d_ls, d_fs, d_pt});
            end
        end
        d_en = 1'b1;
        step();
        n_checks++;
        if ({d_h, d_pt} !== {11'd101, 1'b1}) begin
            n_fail++; $display("FAIL freeze_resume: got h=%0d pt=%b expected h=101 pt=1", d_h, d_pt);
        end
    endtask

    task automatic test_small_raster();
        int h = 13;
        int v = 6;
        logic exp_hs, exp_vs, exp_de, exp_ls, exp_fs;
        s_rst_n = 1'b1;
        s_en    = 1'b1;
        for (int e = 0; e < 200; e++) begin
            step();
            if (h == 13) begin
                h = 0;
                v = (v == 6) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
            exp_hs = (h >= 10 && h <= 12);
            exp_vs = (v != 5);
            exp_de = (h < 8 && v < 4);
            exp_ls = (h == 0);
            exp_fs = (h == 0 && v == 0);
            n_checks++;
            if ({s_h, s_v, s_hs, s_vs, s_de, s_ls, s_fs, s_pt} !==
                {11'(h), 11'(v), exp_hs, exp_vs, exp_de, exp_ls, exp_fs, 1'b1}) begin
                n_fail++; $display("FAIL small_px: got %0d,%0d %b expected %0d,%0d %b", s_h, s_v,
                                   {s_hs, s_vs, s_de, s_ls, s_fs, s_pt}, h, v,
                                   {exp_hs, exp_vs, exp_de, exp_ls, exp_fs, 1'b1});
            end
        end
    endtask

    task automatic test_clk_div();
        int n;
        int exp_h;
        int exp_v;
        k_rst_n = 1'b1;
        k_en    = 1'b1;
        for (int k = 1; k <= 404; k++) begin
            step();
            n     = k / 4;
            exp_h = (n == 0) ? 799 : n - 1;
            exp_v = (n == 0) ? 524 : 0;
            n_checks++;
            if ({k_h, k_v, k_pt, k_ls} !== {11'(exp_h), 11'(exp_v), (k % 4 == 0), (n >= 1 && exp_h == 0)}) begin
                n_fail++; $display("FAIL div_px: clk %0d got h=%0d v=%0d pt=%b ls=%b expected h=%0d v=%0d pt=%b ls=%b",
                                   k, k_h, k_v, k_pt, k_ls, exp_h, exp_v, (k % 4 == 0), (n >= 1 && exp_h == 0));
            end
        end
        k_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if ({k_h, k_pt, k_ls} !== {11'd100, 2'b00}) begin
                n_fail++; $display("FAIL div_freeze: got h=%0d pt=%b ls=%b expected h=100 pt=0 ls=0", k_h, k_pt, k_ls);
            end
        end
        k_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++;
            if ({k_h, k_pt} !== ((i == 4) ? {11'd101, 1'b1} : {11'd100, 1'b0})) begin
                n_fail++; $display("FAIL div_resume: edge %0d got h=%0d pt=%b expected h=%0d pt=%b", i, k_h, k_pt,
                                   (i == 4) ? 101 : 100, (i == 4));
            end
        end
    endtask

    task automatic test_tall_frame();
        int h = 13;
        int v = 524;
        int fs_count = 0;
        int fs_first = -1;
        int fs_last = -1;
        t_rst_n = 1'b1;
        t_en    = 1'b1;
        for (int e = 1; e <= 7352; e++) begin
            step();
            if (h == 13) begin
                h = 0;
                v = (v == 524) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
            if (t_fs) begin
                fs_count++;
                if (fs_first < 0) fs_first = e;
                fs_last = e;
            end
            if (h == 0) begin
                n_checks++;
                if ({t_v, t_vs} !== {11'(v), !(v == 490 || v == 491)}) begin
                    n_fail++; $display("FAIL tall_vsync: got v=%0d vs=%b expected v=%0d vs=%b", t_v, t_vs, v,
                                       !(v == 490 || v == 491));
                end
            end
        end
        n_checks++;
        if (fs_count != 2 || fs_first != 1 || fs_last - fs_first != 7350) begin
            n_fail++; $display("FAIL tall_frame_period: got count=%0d first=%0d period=%0d expected 2,1,7350",
                               fs_count, fs_first, fs_last - fs_first);
        end
        for (int g = 0; g < 4000 && !(h == 5 && v == 200); g++) begin
            step();
            if (h == 13) begin
                h = 0;
                v = (v == 524) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
        end
        n_checks++;
        if ({t_h, t_v} !== {11'd5, 11'd200}) begin
            n_fail++; $display("FAIL async_entry: got %0d,%0d expected 5,200", t_h, t_v);
        end
    endtask

    task automatic test_async_reset();
        #2 t_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({t_h, t_v, t_hs, t_vs, t_de, t_ls, t_fs, t_pt} !== {11'd13, 11'd524, 6'b110000}) begin
            n_fail++; $display("FAIL async_reset: got %0d,%0d %b expected 13,524 110000", t_h, t_v,
                               {t_hs, t_vs, t_de, t_ls, t_fs, t_pt});
        end
        @(negedge clk);
        t_rst_n = 1'b1;
        step();
        n_checks++;
        if ({t_h, t_v, t_fs, t_ls, t_pt} !== {11'd0, 11'd0, 3'b111}) begin
            n_fail++; $display("FAIL async_restart: got %0d,%0d fs=%b ls=%b pt=%b expected 0,0 1 1 1", t_h, t_v,
                               t_fs, t_ls, t_pt);
        end
    endtask

    initial begin
        d_rst_n = 1'b0; d_en = 1'b0;
        s_rst_n = 1'b0; s_en = 1'b0;
        k_rst_n = 1'b0; k_en = 1'b0;
        t_rst_n = 1'b0; t_en = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_first_pixel();
        test_hsync_line();
        test_en_freeze();
        test_small_raster();
        test_clk_div();
        test_tall_frame();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
